// File: rtl/mem_sram_reader_if.sv
// Decoupled (valid/ready) channel used for both the read-request and the
// read-response side of mem_sram_reader.
//
// Handshake: a transfer happens in every cycle where valid and ready are both
// high at the rising clock edge. The master must hold valid and data stable
// until that transfer; once valid is raised it is not withdrawn. Ready may
// change freely and never depends combinationally on valid.
interface mem_sram_reader_if #(
    parameter int W = 32
);
    logic         valid;
    logic         ready;
    logic [W-1:0] data;

    // Producer side of the channel.
    modport master (
        output valid,
        output data,
        input  ready
    );

    // Consumer side of the channel.
    modport slave (
        input  valid,
        input  data,
        output ready
    );
endinterface

// File: rtl/mem_sram_reader.sv
// Read-only asynchronous-SRAM port for the memory arbiter.
// A request carries a byte address. The word address is driven to the SRAM,
// chip/output enables are held low for WAIT_CYCLES cycles, and the last
// sampled word goes into a small in-order response FIFO. A FIFO slot is
// reserved when a request is accepted. The push at the end of an access
// therefore always finds room.
module mem_sram_reader #(
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int SRAM_ADDR_WIDTH = 20,
    parameter int WAIT_CYCLES     = 2,
    parameter int RESP_DEPTH      = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    mem_sram_reader_if.slave           req,
    mem_sram_reader_if.master          resp,
    output logic [SRAM_ADDR_WIDTH-1:0] sram_addr,
    output logic                       sram_ce_n,
    output logic                       sram_oe_n,
    input  logic [DATA_WIDTH-1:0]      sram_rdata,
    output logic                       state_dbg
);

    // Wait counter is 4 bits wide. WAIT_CYCLES is at most 15, so the load
    // value is at most 14.
    localparam int CNT_W = 4;
    localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(WAIT_CYCLES - 1);

    // FIFO sizing. A depth of 1 still gets a 1-bit pointer. The storage
    // array is rounded up to a power of two so every pointer value is a legal
    // index. The pointers still wrap at RESP_DEPTH.
    localparam int PTR_W = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
    localparam int MEM_N = 1 << PTR_W;
    localparam int OCC_W = $clog2(RESP_DEPTH + 1);

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_ACCESS = 1'b1
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [CNT_W-1:0]           wait_q;
    logic [SRAM_ADDR_WIDTH-1:0] sram_addr_q;

    logic [DATA_WIDTH-1:0] mem [MEM_N];
    logic [PTR_W-1:0]      wr_ptr_q;
    logic [PTR_W-1:0]      rd_ptr_q;
    logic [OCC_W-1:0]      occ_q;

    logic [ADDR_WIDTH-1:0] req_addr;
    logic [OCC_W:0]        pending;
    logic                  req_fire;
    logic                  resp_fire;
    logic                  push;

    // Only bits [SRAM_ADDR_WIDTH+1:2] select the word. Byte-lane bits and
    // bits above the SRAM range are ignored on purpose, without any error
    // or alignment check.
    assign req_addr = req.data;
    logic unused_addr_bits;
    assign unused_addr_bits = ^req_addr;

    assign req_fire  = req.valid && req.ready;
    assign resp_fire = resp.valid && resp.ready;

    // The last access cycle is the one where the counter has reached zero.
    // The word on sram_rdata is captured at the end of that cycle.
    assign push = (state_q == S_ACCESS) && (wait_q == '0);

    // Occupied entries plus the one access that may be in flight. The
    // occupied count is registered. A pop therefore frees a slot for the
    // request side one cycle later.
    assign pending = {1'b0, occ_q} + (OCC_W + 1)'(state_q == S_ACCESS);

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(RESP_DEPTH - 1)) begin
            return '0;
        end
        return p + PTR_W'(1);
    endfunction

    // FSM state register; reset returns to IDLE and abandons any access.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: accept moves to ACCESS, counter expiry returns to IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (req_fire) begin
                    state_d = S_ACCESS;
                end
            end
            S_ACCESS: begin
                if (wait_q == '0) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // FSM outputs. Enables and handshakes are forced inactive while reset
    // is held.
    always_comb begin
        req.ready  = 1'b0;
        sram_ce_n  = 1'b1;
        sram_oe_n  = 1'b1;
        resp.valid = rst && (occ_q != '0);
        resp.data  = mem[rd_ptr_q];
        case (state_q)
            S_IDLE: begin
                req.ready = rst && (pending < (OCC_W + 1)'(RESP_DEPTH));
            end
            S_ACCESS: begin
                sram_ce_n = !rst;
                sram_oe_n = !rst;
            end
            default: begin
                req.ready = 1'b0;
            end
        endcase
    end

    // Address latch and wait counter. The address holds until the next
    // accepted request.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wait_q      <= '0;
            sram_addr_q <= '0;
        end else if (req_fire) begin
            wait_q      <= WAIT_LOAD;
            sram_addr_q <= req_addr[SRAM_ADDR_WIDTH+1:2];
        end else if ((state_q == S_ACCESS) && (wait_q != '0)) begin
            wait_q <= wait_q - CNT_W'(1);
        end
    end

    // Response FIFO pointers and occupancy. A push and a pop in the same
    // cycle leave the count unchanged.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= ptr_next(wr_ptr_q);
            end
            if (resp_fire) begin
                rd_ptr_q <= ptr_next(rd_ptr_q);
            end
            case ({push, resp_fire})
                2'b10:   occ_q <= occ_q + OCC_W'(1);
                2'b01:   occ_q <= occ_q - OCC_W'(1);
                default: occ_q <= occ_q;
            endcase
        end
    end

    // Response FIFO storage. Contents need no reset because occupancy
    // gates them.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= sram_rdata;
        end
    end

    assign sram_addr = sram_addr_q;
    assign state_dbg = (state_q == S_ACCESS);

endmodule

// File: tb/tb_mem_sram_reader.sv
// Directed bench for mem_sram_reader.
// Instance a uses the default parameters. Instance b uses WAIT_CYCLES=1 and
// RESP_DEPTH=1. Each modelled SRAM returns a tag in the upper bits with the
// word address in the low 20 bits. An expected response is queued when its
// request is accepted. A response monitor checks order and data.
module tb_mem_sram_reader;

    logic clk;
    logic rst;

    mem_sram_reader_if #(.W(32)) req_a ();
    mem_sram_reader_if #(.W(32)) resp_a ();
    mem_sram_reader_if #(.W(32)) req_b ();
    mem_sram_reader_if #(.W(32)) resp_b ();

    logic [19:0] sram_addr_a, sram_addr_b;
    logic        ce_n_a, oe_n_a, ce_n_b, oe_n_b;
    logic [31:0] sram_rdata_a, sram_rdata_b;
    logic        state_a, state_b;

    logic        rd_ovr;
    logic [31:0] rd_val;

    assign sram_rdata_a = rd_ovr ? rd_val : {12'hABC, sram_addr_a};
    assign sram_rdata_b = {12'h5B0, sram_addr_b};

    mem_sram_reader dut_a (
        .clk        (clk),
        .rst        (rst),
        .req        (req_a),
        .resp       (resp_a),
        .sram_addr  (sram_addr_a),
        .sram_ce_n  (ce_n_a),
        .sram_oe_n  (oe_n_a),
        .sram_rdata (sram_rdata_a),
        .state_dbg  (state_a)
    );

    mem_sram_reader #(.WAIT_CYCLES(1), .RESP_DEPTH(1)) dut_b (
        .clk        (clk),
        .rst        (rst),
        .req        (req_b),
        .resp       (resp_b),
        .sram_addr  (sram_addr_b),
        .sram_ce_n  (ce_n_b),
        .sram_oe_n  (oe_n_b),
        .sram_rdata (sram_rdata_b),
        .state_dbg  (state_b)
    );

    // ---------------- clock / cycle counter ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard ----------------
    int vectors    = 0;
    int miscompares = 0;

    logic [31:0] exp_a_q[$];
    logic [31:0] exp_b_q[$];
    int          resp_cyc_a[$];
    int          resp_cyc_b[$];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // Response monitors: every response transfer must match the oldest
    // expectation.
    always @(negedge clk) begin
        if (resp_a.valid && resp_a.ready) begin
            if (exp_a_q.size() == 0) check_val("a_spurious_resp", 32'(resp_a.valid), 32'd0);
            else check_val("a_resp_data", resp_a.data, exp_a_q.pop_front());
            resp_cyc_a.push_back(cyc);
        end
    end

    always @(negedge clk) begin
        if (resp_b.valid && resp_b.ready) begin
            if (exp_b_q.size() == 0) check_val("b_spurious_resp", 32'(resp_b.valid), 32'd0);
            else check_val("b_resp_data", resp_b.data, exp_b_q.pop_front());
            resp_cyc_b.push_back(cyc);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one request, wait (bounded) for acceptance, and queue its
    // expected response. The task returns one cycle after the accept
    // cycle, with valid dropped.
    task automatic issue_a(input logic [31:0] addr, input logic [31:0] exp, output int acc);
        bit done;
        done = 1'b0;
        acc = -1;
        req_a.valid = 1'b1;
        req_a.data  = addr;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if (req_a.ready) begin
                done = 1'b1;
                acc  = cyc;
                exp_a_q.push_back(exp);
            end
            step();
        end
        req_a.valid = 1'b0;
        check_val("a_accept", 32'(done), 32'd1);
    endtask

    task automatic issue_b(input logic [31:0] addr, input logic [31:0] exp, output int acc);
        bit done;
        done = 1'b0;
        acc = -1;
        req_b.valid = 1'b1;
        req_b.data  = addr;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if (req_b.ready) begin
                done = 1'b1;
                acc  = cyc;
                exp_b_q.push_back(exp);
            end
            step();
        end
        req_b.valid = 1'b0;
        check_val("b_accept", 32'(done), 32'd1);
    endtask

    task automatic drain_a(input int budget);
        for (int i = 0; i < budget && exp_a_q.size() != 0; i++) step();
        check_val("a_drain_left", 32'(exp_a_q.size()), 32'd0);
    endtask

    task automatic drain_b(input int budget);
        for (int i = 0; i < budget && exp_b_q.size() != 0; i++) step();
        check_val("b_drain_left", 32'(exp_b_q.size()), 32'd0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int t0, t1, t2, acc;

        rst = 1'b0;
        rd_ovr = 1'b0;
        rd_val = '0;
        req_a.valid = 1'b0;  req_a.data = '0;  resp_a.ready = 1'b0;
        req_b.valid = 1'b0;  req_b.data = '0;  resp_b.ready = 1'b0;

        // Reset state, while reset is held and directly after release.
        step();
        step();
        check_val("rst_req_ready",  32'(req_a.ready),  32'd0);
        check_val("rst_resp_valid", 32'(resp_a.valid), 32'd0);
        check_val("rst_ce_n",       32'(ce_n_a),       32'd1);
        check_val("rst_oe_n",       32'(oe_n_a),       32'd1);
        check_val("rst_sram_addr",  32'(sram_addr_a),  32'd0);
        check_val("rst_state",      32'(state_a),      32'd0);
        rst = 1'b1;
        step();
        check_val("post_rst_valid", 32'(resp_a.valid), 32'd0);
        check_val("post_rst_ce_n",  32'(ce_n_a),       32'd1);
        check_val("post_rst_addr",  32'(sram_addr_a),  32'd0);

        // Single read: the word sampled in the last access cycle is returned.
        resp_a.ready = 1'b1;
        issue_a(32'h0000_0104, 32'h2222_2222, t0);
        rd_ovr = 1'b1;
        rd_val = 32'h1111_1111;
        check_val("single_addr",  32'(sram_addr_a), 32'h41);
        check_val("single_ce1",   32'(ce_n_a),      32'd0);
        check_val("single_oe1",   32'(oe_n_a),      32'd0);
        check_val("single_rdy1",  32'(req_a.ready), 32'd0);
        step();
        rd_val = 32'h2222_2222;
        check_val("single_ce2",   32'(ce_n_a),       32'd0);
        check_val("single_val2",  32'(resp_a.valid), 32'd0);
        step();
        rd_val = 32'h3333_3333;
        check_val("single_ce3",   32'(ce_n_a),       32'd1);
        check_val("single_val3",  32'(resp_a.valid), 32'd1);
        check_val("single_data3", resp_a.data,       32'h2222_2222);
        step();
        rd_ovr = 1'b0;
        check_val("single_lat",   32'(resp_cyc_a[0] - t0), 32'd3);
        check_val("single_hold",  32'(sram_addr_a),        32'h41);
        drain_a(10);

        // Back-to-back reads with the response side always ready.
        resp_cyc_a.delete();
        issue_a(32'h0, 32'hABC0_0000, t0);
        issue_a(32'h4, 32'hABC0_0001, t1);
        issue_a(32'h8, 32'hABC0_0002, t2);
        drain_a(20);
        check_val("b2b_acc1",  32'(t1 - t0), 32'd3);
        check_val("b2b_acc2",  32'(t2 - t0), 32'd6);
        check_val("b2b_resp0", 32'(resp_cyc_a[0] - t0), 32'd3);
        check_val("b2b_resp1", 32'(resp_cyc_a[1] - t0), 32'd6);
        check_val("b2b_resp2", 32'(resp_cyc_a[2] - t0), 32'd9);

        // Backpressure: two reads fill the FIFO and the third must wait.
        resp_a.ready = 1'b0;
        issue_a(32'h10, 32'hABC0_0004, t0);
        issue_a(32'h14, 32'hABC0_0005, t1);
        req_a.valid = 1'b1;
        req_a.data  = 32'h18;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_val("bp_ready_low", 32'(req_a.ready),  32'd0);
            check_val("bp_valid",     32'(resp_a.valid), 32'd1);
            check_val("bp_data_hold", resp_a.data,       32'hABC0_0004);
            check_val("bp_addr_hold", 32'(sram_addr_a),  32'h5);
            step();
        end
        resp_a.ready = 1'b1;
        resp_cyc_a.delete();
        issue_a(32'h18, 32'hABC0_0006, t2);
        check_val("bp_acc_after_pop", 32'(t2 - resp_cyc_a[0]), 32'd1);
        drain_a(20);

        // Reset during an access: the read is abandoned and nothing is
        // emitted.
        issue_a(32'h20, 32'hABC0_0008, t0);
        rst = 1'b0;
        exp_a_q.delete();
        #1;
        check_val("mid_rst_ready", 32'(req_a.ready), 32'd0);
        check_val("mid_rst_ce_n",  32'(ce_n_a),      32'd1);
        step();
        rst = 1'b1;
        #1;
        check_val("mid_ce_n",   32'(ce_n_a),       32'd1);
        check_val("mid_oe_n",   32'(oe_n_a),       32'd1);
        check_val("mid_addr",   32'(sram_addr_a),  32'd0);
        check_val("mid_ready",  32'(req_a.ready),  32'd1);
        check_val("mid_valid",  32'(resp_a.valid), 32'd0);
        for (int i = 0; i < 4; i++) step();
        check_val("mid_valid_later", 32'(resp_a.valid), 32'd0);

        // Reset with a buffered response: it is discarded, not emitted.
        resp_a.ready = 1'b0;
        issue_a(32'h30, 32'hABC0_000C, t0);
        step();
        step();
        check_val("disc_buffered", 32'(resp_a.valid), 32'd1);
        rst = 1'b0;
        resp_a.ready = 1'b1;
        exp_a_q.delete();
        step();
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_val("disc_valid", 32'(resp_a.valid), 32'd0);
            step();
        end

        // Address masking: byte-lane and out-of-range bits are ignored.
        issue_a(32'hFFFF_FFFF, 32'hABCF_FFFF, t0);
        check_val("mask_addr", 32'(sram_addr_a), 32'h000F_FFFF);
        drain_a(10);

        // Minimal configuration: one access cycle and a one-entry FIFO.
        resp_b.ready = 1'b1;
        issue_b(32'h44, 32'h5B00_0011, t0);
        check_val("b_ce1",    32'(ce_n_b),       32'd0);
        check_val("b_oe1",    32'(oe_n_b),       32'd0);
        check_val("b_addr",   32'(sram_addr_b),  32'h11);
        check_val("b_valid1", 32'(resp_b.valid), 32'd0);
        step();
        check_val("b_ce2",    32'(ce_n_b),       32'd1);
        check_val("b_valid2", 32'(resp_b.valid), 32'd1);
        check_val("b_data2",  resp_b.data,       32'h5B00_0011);
        check_val("b_full_rdy", 32'(req_b.ready), 32'd0);
        step();
        check_val("b_lat",    32'(resp_cyc_b[0] - t0), 32'd2);
        check_val("b_rdy3",   32'(req_b.ready),        32'd1);

        resp_b.ready = 1'b0;
        issue_b(32'h48, 32'h5B00_0012, t1);
        req_b.valid = 1'b1;
        req_b.data  = 32'h4C;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_val("b_bp_ready", 32'(req_b.ready), 32'd0);
            step();
        end
        check_val("b_bp_data", resp_b.data, 32'h5B00_0012);
        resp_b.ready = 1'b1;
        resp_cyc_b.delete();
        issue_b(32'h4C, 32'h5B00_0013, acc);
        check_val("b_acc_after_pop", 32'(acc - resp_cyc_b[0]), 32'd1);
        drain_b(10);

        step();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Safety net so the run always terminates.
    initial begin
        #100000;
        check_val("global_timeout", 32'd1, 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
